// File: rtl/hsem_lock_arb.sv
// HSEM semaphore lock table with a round-robin two-core LOCK/UNLOCK arbiter.
// Each operation takes three cycles: accept (IDLE), table update (EXEC), response (RESP).
module hsem_lock_arb #(
  parameter int unsigned NUM_SEM      = 8,
  parameter int unsigned ID_WIDTH     = 5,
  parameter int unsigned SEMERR_WIDTH = 32
) (
  input  logic                    hclk,
  input  logic                    hreset,
  input  logic                    req_vld_0,
  input  logic                    req_op_0,
  input  logic [ID_WIDTH-1:0]     req_id_0,
  output logic                    req_rdy_0,
  output logic                    resp_vld_0,
  output logic                    resp_ok_0,
  output logic [SEMERR_WIDTH-1:0] semerr_0,
  output logic                    free_ntf_0,
  input  logic                    req_vld_1,
  input  logic                    req_op_1,
  input  logic [ID_WIDTH-1:0]     req_id_1,
  output logic                    req_rdy_1,
  output logic                    resp_vld_1,
  output logic                    resp_ok_1,
  output logic [SEMERR_WIDTH-1:0] semerr_1,
  output logic                    free_ntf_1,
  input  logic                    rel_all_0,
  input  logic                    rel_all_1,
  output logic [NUM_SEM-1:0]      sem_lock,
  output logic [NUM_SEM-1:0]      sem_owner
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e                r_state, w_state_nxt;
  logic                  r_last_grant;
  logic                  r_core;
  logic                  r_op;
  logic [ID_WIDTH-1:0]   r_id;
  logic [NUM_SEM-1:0]    r_lock, r_owner, r_wait0, r_wait1;
  logic [NUM_SEM-1:0]    w_lock_nxt, w_owner_nxt, w_wait0_nxt, w_wait1_nxt;
  logic                  r_ok, w_ok_nxt;
  logic [1:0]            r_err, w_err_nxt;
  logic                  r_ntf0, r_ntf1, w_ntf0_nxt, w_ntf1_nxt;

  logic                  w_rel_any;
  logic                  w_gnt;
  logic                  w_gnt_core;
  logic [NUM_SEM-1:0]    w_rel0_mask, w_rel1_mask;
  logic                  w_id_ok;
  logic [NUM_SEM-1:0]    w_oh;
  logic                  w_held;
  logic                  w_owner_bit;
  logic                  w_self;

  // Release requests pre-empt arbitration; on a tie the core not granted last wins.
  assign w_rel_any  = rel_all_0 | rel_all_1;
  assign w_gnt_core = (req_vld_0 & req_vld_1) ? ~r_last_grant : req_vld_1;
  assign w_gnt      = (r_state == StIdle) & ~w_rel_any & (req_vld_0 | req_vld_1);

  assign w_rel0_mask = rel_all_0 ? (r_lock & ~r_owner) : '0;
  assign w_rel1_mask = rel_all_1 ? (r_lock & r_owner) : '0;

  assign w_id_ok     = 32'(r_id) < NUM_SEM;
  assign w_oh        = w_id_ok ? ({{(NUM_SEM-1){1'b0}}, 1'b1} << r_id) : '0;
  assign w_held      = |(r_lock & w_oh);
  assign w_owner_bit = |(r_owner & w_oh);
  assign w_self      = w_held & (w_owner_bit == r_core);

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_gnt) w_state_nxt = StExec;
      StExec:  w_state_nxt = StResp;
      StResp:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    req_rdy_0  = w_gnt & ~w_gnt_core;
    req_rdy_1  = w_gnt & w_gnt_core;
    resp_vld_0 = (r_state == StResp) & ~r_core;
    resp_vld_1 = (r_state == StResp) & r_core;
    resp_ok_0  = resp_vld_0 & r_ok;
    resp_ok_1  = resp_vld_1 & r_ok;
    semerr_0   = resp_vld_0 ? SEMERR_WIDTH'(r_err) : '0;
    semerr_1   = resp_vld_1 ? SEMERR_WIDTH'(r_err) : '0;
    free_ntf_0 = r_ntf0;
    free_ntf_1 = r_ntf1;
    sem_lock   = r_lock;
    sem_owner  = r_owner;
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_last_grant <= 1'b1;
      r_core       <= 1'b0;
      r_op         <= 1'b0;
      r_id         <= '0;
    end else if (w_gnt) begin
      r_last_grant <= w_gnt_core;
      r_core       <= w_gnt_core;
      r_op         <= w_gnt_core ? req_op_1 : req_op_0;
      r_id         <= w_gnt_core ? req_id_1 : req_id_0;
    end
  end

  always_comb begin
    w_lock_nxt  = r_lock;
    w_owner_nxt = r_owner;
    w_wait0_nxt = r_wait0;
    w_wait1_nxt = r_wait1;
    w_ok_nxt    = r_ok;
    w_err_nxt   = r_err;
    w_ntf0_nxt  = 1'b0;
    w_ntf1_nxt  = 1'b0;
    if (r_state == StIdle) begin
      // A waiter on the other core is told its semaphore came free.
      w_lock_nxt  = r_lock & ~(w_rel0_mask | w_rel1_mask);
      w_owner_nxt = r_owner & ~w_rel1_mask;
      w_ntf0_nxt  = |(w_rel1_mask & r_wait0);
      w_ntf1_nxt  = |(w_rel0_mask & r_wait1);
      w_wait0_nxt = r_wait0 & ~w_rel1_mask;
      w_wait1_nxt = r_wait1 & ~w_rel0_mask;
    end else if (r_state == StExec) begin
      w_ok_nxt  = 1'b0;
      w_err_nxt = 2'd0;
      if (!w_id_ok) begin
        w_err_nxt = 2'd1;
      end else if (r_op) begin
        if (!w_held) begin
          w_lock_nxt  = r_lock | w_oh;
          w_owner_nxt = r_core ? (r_owner | w_oh) : (r_owner & ~w_oh);
          w_ok_nxt    = 1'b1;
          if (r_core) w_wait1_nxt = r_wait1 & ~w_oh;
          else        w_wait0_nxt = r_wait0 & ~w_oh;
        end else if (w_self) begin
          w_err_nxt = 2'd3;
        end else if (r_core) begin
          w_wait1_nxt = r_wait1 | w_oh;
        end else begin
          w_wait0_nxt = r_wait0 | w_oh;
        end
      end else if (w_self) begin
        w_lock_nxt  = r_lock & ~w_oh;
        w_owner_nxt = r_owner & ~w_oh;
        w_ok_nxt    = 1'b1;
        if (r_core) begin
          w_ntf0_nxt  = |(r_wait0 & w_oh);
          w_wait0_nxt = r_wait0 & ~w_oh;
        end else begin
          w_ntf1_nxt  = |(r_wait1 & w_oh);
          w_wait1_nxt = r_wait1 & ~w_oh;
        end
      end else begin
        w_err_nxt = 2'd2;
      end
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_lock  <= '0;
      r_owner <= '0;
      r_wait0 <= '0;
      r_wait1 <= '0;
      r_ok    <= 1'b0;
      r_err   <= 2'd0;
      r_ntf0  <= 1'b0;
      r_ntf1  <= 1'b0;
    end else begin
      r_lock  <= w_lock_nxt;
      r_owner <= w_owner_nxt;
      r_wait0 <= w_wait0_nxt;
      r_wait1 <= w_wait1_nxt;
      r_ok    <= w_ok_nxt;
      r_err   <= w_err_nxt;
      r_ntf0  <= w_ntf0_nxt;
      r_ntf1  <= w_ntf1_nxt;
    end
  end

endmodule

// File: doc/hsem_lock_arb.md
Name: hsem_lock_arb

Overview:
- Semaphore lock table and two-core request arbiter for the HSEM block.
- Accepts LOCK/UNLOCK requests from core 0 and core 1, arbitrates them round-robin, and updates per-semaphore lock/owner state.
- Drives per-core semerr codes into the HSEM interrupt/error controller.
- Raises a free-notify pulse so a core whose lock attempt failed can be interrupted for a task switch.

Parameters:
NUM_SEM, 8, number of semaphores (2..32)
ID_WIDTH, 5, semaphore index width; IDs >= NUM_SEM are invalid
SEMERR_WIDTH, 32, width of semerr outputs

Ports:
hclk  input  1  clock
hreset  input  1  asynchronous active-high reset
req_vld_0  input  1  core 0 request valid
req_op_0  input  1  core 0 op: 1=LOCK, 0=UNLOCK
req_id_0  input  ID_WIDTH  core 0 semaphore index
req_rdy_0  output  1  core 0 request accepted this cycle
resp_vld_0  output  1  core 0 response pulse
resp_ok_0  output  1  core 0 op succeeded (valid with resp_vld_0)
semerr_0  output  SEMERR_WIDTH  core 0 error code pulse
free_ntf_0  output  1  pulse: a semaphore core 0 failed to get is now free
(identical set with suffix _1 for core 1)
rel_all_0  input  1  pulse: release every semaphore owned by core 0
rel_all_1  input  1  same for core 1
sem_lock  output  NUM_SEM  lock bit per semaphore
sem_owner  output  NUM_SEM  owner per semaphore (0=core 0, 1=core 1; 0 when unlocked)

Behaviour:
- Reset: all outputs 0; lock, owner and waiter tables cleared; FSM=IDLE; last_grant=1, so core 0 wins the first tie. Reset mid-operation aborts the operation with no response.
- FSM states IDLE -> EXEC -> RESP -> IDLE. Throughput is one operation per 3 cycles.
- IDLE:
  - rel_all_x has priority over requests. Clear lock/owner for all semaphores owned by that core; rdy stays low; stay in IDLE. If both rel_all are asserted, both are applied the same cycle.
  - Otherwise, if any req_vld: grant core 0 if only core 0 is valid, core 1 if only core 1, else the core != last_grant.
  - On grant: req_rdy_x=1 combinationally for one cycle; latch core, op and id; update last_grant; go to EXEC.
  - req_rdy is 0 in EXEC and RESP. Requesters hold req_vld and fields stable until rdy.
- EXEC: evaluate and update the table. Result and error code are registered. Error codes:
  - id >= NUM_SEM: ok=0, err=1. No state change.
  - LOCK, unlocked: set lock, owner=core; ok=1.
  - LOCK, held by other core: ok=0, err=0; set waiter[core][id].
  - LOCK, held by self: ok=0, err=3 (relock).
  - UNLOCK, held by self: clear lock/owner; ok=1. If waiter[other][id]=1, clear it and pulse free_ntf_other in RESP.
  - UNLOCK, not held by self (free or other owner): ok=0, err=2.
  - rel_all releases also fire free_ntf to the other core for each released id with its waiter bit set, one cycle after the release. Those waiter bits are cleared.
- RESP: for the granted core, resp_vld_x=1 and resp_ok_x valid for exactly one cycle; semerr_x=error code for that same cycle only; the other core's semerr stays 0. Return to IDLE.
- Latency: accept at cycle N, response at N+2.
- Waiter bits are cleared when that core later locks the semaphore successfully.
- sem_lock/sem_owner are registered and reflect the table after EXEC, visible from the RESP cycle.

Test Plan:
- Reset, then core 0 LOCK id 3 -> rdy_0 at cycle 0, resp_vld_0=1, ok=1 at cycle 2; sem_lock=0x08, sem_owner[3]=0.
- Both cores LOCK id 5 in the same cycle after reset -> core 0 granted first, ok=1. Core 1 granted 3 cycles later, ok=0, semerr_1=0. Core 0 UNLOCK id 5 -> ok=1 and free_ntf_1 pulse 1 cycle in its RESP.
- Core 1 UNLOCK id 2 while unlocked -> ok=0, semerr_1=2 for one cycle, then 0. Core 0 LOCK id 9 with NUM_SEM=8 -> semerr_0=1, table unchanged.
- Core 0 LOCK id 1 twice -> second response ok=0, semerr_0=3; lock retained.
- Core 1 holds ids 0 and 4, core 0 waiting on 4; pulse rel_all_1 -> sem_lock=0 next cycle, free_ntf_0 pulses once. A req_vld_0 asserted concurrently sees rdy only on the following cycle.
- Assert hreset while in EXEC -> no resp_vld; all outputs 0; a subsequent core 1-only request is granted normally.
